// File: rtl/multiport_prf.sv
// ---------------------------------------------------------------------------
// multiport_prf -- physical register file with a round-robin writeback arbiter
//
// Holds REG_SIZE registers of XLEN bits, each with a busy bit. NUM_RD
// combinational read ports return data and busy for the addressed register.
// NUM_WB writeback requesters compete for NUM_WR physical write ports. A
// round-robin scan starting at rr_ptr grants the first NUM_WR valid requesters.
// NUM_ALLOC allocate ports set busy bits. Register 0 is hardwired to data 0
// and busy 0.
//
// Optional feature: define PRF_BYPASS_EN to forward same-cycle granted write
// data to matching read ports (busy reads as 0 for a forwarded value).
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   rd_addr_i      NUM_RD read addresses, packed
//   rd_data_o      NUM_RD read data words, packed
//   rd_busy_o      busy bit of each addressed register
//   wb_valid_i     writeback request per requester
//   wb_addr_i      writeback destination per requester, packed
//   wb_data_i      writeback data per requester, packed
//   wb_ready_o     grant per requester (combinational)
//   alloc_valid_i  busy-set request per allocate port
//   alloc_prd_i    register to mark busy per allocate port, packed
// ---------------------------------------------------------------------------
module multiport_prf #(
  parameter int REG_SIZE       = 48,
  parameter int REG_SIZE_WIDTH = 6,
  parameter int XLEN           = 64,
  parameter int NUM_RD         = 6,
  parameter int NUM_WB         = 6,
  parameter int NUM_WR         = 2,
  parameter int NUM_ALLOC      = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_RD*REG_SIZE_WIDTH-1:0]    rd_addr_i,
  output logic [NUM_RD*XLEN-1:0]              rd_data_o,
  output logic [NUM_RD-1:0]                   rd_busy_o,
  input  logic [NUM_WB-1:0]                   wb_valid_i,
  input  logic [NUM_WB*REG_SIZE_WIDTH-1:0]    wb_addr_i,
  input  logic [NUM_WB*XLEN-1:0]              wb_data_i,
  output logic [NUM_WB-1:0]                   wb_ready_o,
  input  logic [NUM_ALLOC-1:0]                alloc_valid_i,
  input  logic [NUM_ALLOC*REG_SIZE_WIDTH-1:0] alloc_prd_i
);

  localparam int PTR_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

  typedef logic [REG_SIZE_WIDTH-1:0] addr_t;
  typedef logic [XLEN-1:0]           data_t;
  typedef logic [PTR_W-1:0]          ptr_t;

  if (NUM_WR < 1 || NUM_WR > NUM_WB) begin : g_bad_cfg
    $error("multiport_prf: NUM_WR must satisfy 1 <= NUM_WR <= NUM_WB");
  end

  // Unpacked views of the packed port buses
  addr_t rd_addr   [NUM_RD];
  data_t rd_data   [NUM_RD];
  addr_t wb_addr   [NUM_WB];
  data_t wb_data   [NUM_WB];
  addr_t alloc_prd [NUM_ALLOC];

  // Architectural state
  data_t               regs [REG_SIZE];
  logic [REG_SIZE-1:0] busy;
  ptr_t                rr_ptr;

  // Arbiter results, listed in scan order (slot 0 is scanned first)
  logic [NUM_WB-1:0] grant;
  ptr_t              rr_ptr_nxt;
  logic              gnt_vld [NUM_WR];
  ptr_t              gnt_idx [NUM_WR];
  logic              wr_vld  [NUM_WR];
  addr_t             wr_addr [NUM_WR];
  data_t             wr_data [NUM_WR];

  // (base + off) mod NUM_WB; both operands are below NUM_WB so one
  // conditional subtract is enough.
  function automatic ptr_t wrap_add(input ptr_t base, input int unsigned off);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + (PTR_W+1)'(off);
    if (sum >= (PTR_W+1)'(NUM_WB)) sum = sum - (PTR_W+1)'(NUM_WB);
    return sum[PTR_W-1:0];
  endfunction

  // Addresses at or above REG_SIZE have no storage behind them.
  function automatic logic in_range(input addr_t a);
    return ({1'b0, a} < (REG_SIZE_WIDTH+1)'(REG_SIZE));
  endfunction

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_unpack
    assign rd_addr[k] = rd_addr_i[k*REG_SIZE_WIDTH +: REG_SIZE_WIDTH];
    assign rd_data_o[k*XLEN +: XLEN] = rd_data[k];
  end

  for (genvar r = 0; r < NUM_WB; r++) begin : g_wb_unpack
    assign wb_addr[r] = wb_addr_i[r*REG_SIZE_WIDTH +: REG_SIZE_WIDTH];
    assign wb_data[r] = wb_data_i[r*XLEN +: XLEN];
  end

  for (genvar j = 0; j < NUM_ALLOC; j++) begin : g_alloc_unpack
    assign alloc_prd[j] = alloc_prd_i[j*REG_SIZE_WIDTH +: REG_SIZE_WIDTH];
  end

  // Round-robin arbiter: scan from rr_ptr, grant the first NUM_WR valid
  // requesters; the pointer moves just past the last one granted.
  always_comb begin : arb
    int   cnt;
    ptr_t idx;
    grant      = '0;
    rr_ptr_nxt = rr_ptr;
    cnt        = 0;
    idx        = '0;
    for (int s = 0; s < NUM_WR; s++) begin
      gnt_vld[s] = 1'b0;
      gnt_idx[s] = '0;
    end
    for (int i = 0; i < NUM_WB; i++) begin
      idx = wrap_add(rr_ptr, i);
      if (wb_valid_i[idx] && cnt < NUM_WR) begin
        grant[idx] = 1'b1;
        for (int s = 0; s < NUM_WR; s++) begin
          if (cnt == s) begin
            gnt_vld[s] = 1'b1;
            gnt_idx[s] = idx;
          end
        end
        cnt        = cnt + 1;
        rr_ptr_nxt = wrap_add(idx, 1);
      end
    end
  end

  // Grants are suppressed while reset is held so nothing is handed out.
  assign wb_ready_o = rst_n ? grant : '0;

  always_comb begin
    for (int s = 0; s < NUM_WR; s++) begin
      wr_vld[s]  = gnt_vld[s] & rst_n;
      wr_addr[s] = wb_addr[gnt_idx[s]];
      wr_data[s] = wb_data[gnt_idx[s]];
    end
  end

  // State update. Writes are applied in scan order so the later grant to a
  // shared address wins; allocations come after writes so a same-cycle
  // allocate leaves the register busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_SIZE; r++) regs[r] <= '0;
      busy   <= '0;
      rr_ptr <= '0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
      for (int s = 0; s < NUM_WR; s++) begin
        if (wr_vld[s] && wr_addr[s] != '0 && in_range(wr_addr[s])) begin
          regs[wr_addr[s]] <= wr_data[s];
          busy[wr_addr[s]] <= 1'b0;
        end
      end
      for (int j = 0; j < NUM_ALLOC; j++) begin
        if (alloc_valid_i[j] && alloc_prd[j] != '0 && in_range(alloc_prd[j])) begin
          busy[alloc_prd[j]] <= 1'b1;
        end
      end
    end
  end

  // Read ports: register 0 and out-of-range addresses read as zero / not busy
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data[k]   = '0;
      rd_busy_o[k] = 1'b0;
      if (rd_addr[k] != '0 && in_range(rd_addr[k])) begin
        rd_data[k]   = regs[rd_addr[k]];
        rd_busy_o[k] = busy[rd_addr[k]];
      end
`ifdef PRF_BYPASS_EN
      // Later slots override earlier ones, matching write priority.
      for (int s = 0; s < NUM_WR; s++) begin
        if (wr_vld[s] && rd_addr[k] != '0 && wr_addr[s] == rd_addr[k]) begin
          rd_data[k]   = wr_data[s];
          rd_busy_o[k] = 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_multiport_prf.sv
module tb_multiport_prf;
  localparam int RS = 48, AW = 6, XL = 64, NRD = 6, NWB = 6, NWR = 2, NAL = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr_i;
  logic [NRD*XL-1:0]   rd_data_o;
  logic [NRD-1:0]      rd_busy_o;
  logic [NWB-1:0]      wb_valid_i;
  logic [NWB*AW-1:0]   wb_addr_i;
  logic [NWB*XL-1:0]   wb_data_i;
  logic [NWB-1:0]      wb_ready_o;
  logic [NAL-1:0]      alloc_valid_i;
  logic [NAL*AW-1:0]   alloc_prd_i;

  always #5 clk = ~clk;

  multiport_prf #(
    .REG_SIZE(RS), .REG_SIZE_WIDTH(AW), .XLEN(XL), .NUM_RD(NRD),
    .NUM_WB(NWB), .NUM_WR(NWR), .NUM_ALLOC(NAL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .wb_ready_o(wb_ready_o),
    .alloc_valid_i(alloc_valid_i), .alloc_prd_i(alloc_prd_i)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input logic [63:0] obs);
    exp_t e;
    if (sbq.size() == 0) begin
      check_eq("sb_underflow", 64'(sbq.size()), 64'd1);
    end else begin
      e = sbq.pop_front();
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int k, input int a);
    rd_addr_i[k*AW +: AW] = AW'(a);
  endtask

  task automatic set_wb(input int r, input logic v, input int a, input logic [63:0] d);
    wb_valid_i[r]         = v;
    wb_addr_i[r*AW +: AW] = AW'(a);
    wb_data_i[r*XL +: XL] = d;
  endtask

  task automatic set_alloc(input int j, input logic v, input int a);
    alloc_valid_i[j]        = v;
    alloc_prd_i[j*AW +: AW] = AW'(a);
  endtask

  function automatic logic [63:0] rdata(input int k);
    return rd_data_o[k*XL +: XL];
  endfunction

  function automatic logic [63:0] rbusy(input int k);
    return 64'(rd_busy_o[k]);
  endfunction

  logic [5:0] exp_g [3];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    rd_addr_i     = '0;
    wb_valid_i    = '0;
    wb_addr_i     = '0;
    wb_data_i     = '0;
    alloc_valid_i = '0;
    alloc_prd_i   = '0;

    // Requests presented during reset must not be granted
    wb_valid_i = 6'h3F;
    sb_push("rst_ready", 64'h0);
    #3;
    sb_pop(64'(wb_ready_o));
    tick();
    tick();
    wb_valid_i = '0;
    rst_n      = 1'b1;

    // Every address reads zero, not busy; no grants without requests
    for (int g = 0; g < RS / NRD; g++) begin
      for (int k = 0; k < NRD; k++) begin
        set_rd(k, g * NRD + k);
        sb_push($sformatf("rst_data_p%0d", g * NRD + k), 64'h0);
        sb_push($sformatf("rst_busy_p%0d", g * NRD + k), 64'h0);
      end
      sb_push("idle_ready", 64'h0);
      #2;
      for (int k = 0; k < NRD; k++) begin
        sb_pop(rdata(k));
        sb_pop(rbusy(k));
      end
      sb_pop(64'(wb_ready_o));
    end

    // Allocate p5, then write p5 from requester 5 (rr_ptr 0)
    tick();
    rd_addr_i = '0;
    set_rd(0, 5);
    set_alloc(0, 1'b1, 5);
    sb_push("alloc_pre_busy", 64'h0);
    #3;
    sb_pop(rbusy(0));
    tick();
    alloc_valid_i = '0;
    sb_push("alloc_busy", 64'h1);
    sb_push("alloc_data", 64'h0);
    #1;
    sb_pop(rbusy(0));
    sb_pop(rdata(0));
    set_wb(5, 1'b1, 5, 64'hDEAD);
    sb_push("wr5_ready", 64'h20);
`ifdef PRF_BYPASS_EN
    sb_push("wr5_cyc_data", 64'hDEAD);
    sb_push("wr5_cyc_busy", 64'h0);
`else
    sb_push("wr5_cyc_data", 64'h0);
    sb_push("wr5_cyc_busy", 64'h1);
`endif
    #3;
    sb_pop(64'(wb_ready_o));
    sb_pop(rdata(0));
    sb_pop(rbusy(0));
    tick();
    wb_valid_i = '0;
    sb_push("wr5_data", 64'hDEAD);
    sb_push("wr5_busy", 64'h0);
    #1;
    sb_pop(rdata(0));
    sb_pop(rbusy(0));

    // All six requesters valid, two write ports: three rounds of grants
    exp_g[0] = 6'h03;
    exp_g[1] = 6'h0C;
    exp_g[2] = 6'h30;
    for (int r = 0; r < NWB; r++) set_wb(r, 1'b1, 10 + r, 64'h1000 + 64'(r));
    for (int c = 0; c < 3; c++) begin
      sb_push($sformatf("rr_grant_c%0d", c), 64'(exp_g[c]));
      #3;
      sb_pop(64'(wb_ready_o));
      tick();
      wb_valid_i = wb_valid_i & ~exp_g[c];
    end
    for (int k = 0; k < NRD; k++) begin
      set_rd(k, 10 + k);
      sb_push($sformatf("rr_data_p%0d", 10 + k), 64'h1000 + 64'(k));
      sb_push($sformatf("rr_busy_p%0d", 10 + k), 64'h0);
    end
    #1;
    for (int k = 0; k < NRD; k++) begin
      sb_pop(rdata(k));
      sb_pop(rbusy(k));
    end

    // Requesters 1 and 3 both write p7 with rr_ptr back at 0: requester 3 wins
    rd_addr_i = '0;
    set_wb(1, 1'b1, 7, 64'hA1);
    set_wb(3, 1'b1, 7, 64'hA3);
    sb_push("same_addr_ready", 64'h0A);
    #3;
    sb_pop(64'(wb_ready_o));
    tick();
    wb_valid_i = '0;
    set_rd(0, 7);
    sb_push("same_addr_p7", 64'hA3);
    #1;
    sb_pop(rdata(0));

    // Write and allocate of p0 are both discarded (rr_ptr 4)
    set_rd(0, 0);
    set_wb(4, 1'b1, 0, 64'hFFFF);
    set_alloc(1, 1'b1, 0);
    sb_push("p0_ready", 64'h10);
    sb_push("p0_cyc_data", 64'h0);
    sb_push("p0_cyc_busy", 64'h0);
    #3;
    sb_pop(64'(wb_ready_o));
    sb_pop(rdata(0));
    sb_pop(rbusy(0));
    tick();
    wb_valid_i    = '0;
    alloc_valid_i = '0;
    sb_push("p0_data", 64'h0);
    sb_push("p0_busy", 64'h0);
    #1;
    sb_pop(rdata(0));
    sb_pop(rbusy(0));

    // Wraparound from rr_ptr 5, plus allocate and write of p9 in one cycle
    set_wb(5, 1'b1, 9, 64'h99);
    set_wb(0, 1'b1, 20, 64'h20);
    set_wb(1, 1'b1, 21, 64'h21);
    set_alloc(0, 1'b1, 9);
    sb_push("wrap_ready0", 64'h21);
    #3;
    sb_pop(64'(wb_ready_o));
    tick();
    alloc_valid_i = '0;
    wb_valid_i    = 6'h02;
    sb_push("wrap_ready1", 64'h02);
    #3;
    sb_pop(64'(wb_ready_o));
    tick();
    wb_valid_i = '0;
    set_rd(0, 9);
    set_rd(1, 20);
    set_rd(2, 21);
    sb_push("wa_p9_data", 64'h99);
    sb_push("wa_p9_busy", 64'h1);
    sb_push("wrap_p20", 64'h20);
    sb_push("wrap_p21", 64'h21);
    sb_push("wrap_idle_ready", 64'h0);
    #1;
    sb_pop(rdata(0));
    sb_pop(rbusy(0));
    sb_pop(rdata(1));
    sb_pop(rdata(2));
    sb_pop(64'(wb_ready_o));

    // Reset in the middle of a cycle with four requests pending (rr_ptr 2)
    set_rd(1, 10);
    for (int r = 2; r < NWB; r++) set_wb(r, 1'b1, 30 + r, 64'h300 + 64'(r));
    sb_push("pend_ready", 64'h0C);
    #2;
    sb_pop(64'(wb_ready_o));
    rst_n = 1'b0;
    sb_push("mid_rst_ready", 64'h0);
    sb_push("mid_rst_p9_data", 64'h0);
    sb_push("mid_rst_p9_busy", 64'h0);
    sb_push("mid_rst_p10", 64'h0);
    #1;
    sb_pop(64'(wb_ready_o));
    sb_pop(rdata(0));
    sb_pop(rbusy(0));
    sb_pop(rdata(1));
    tick();
    tick();
    wb_valid_i = '0;
    rst_n      = 1'b1;
    for (int r = 0; r < NWB; r++) set_wb(r, 1'b1, 40 + r, 64'h400 + 64'(r));
    sb_push("post_rst_ready", 64'h03);
    #3;
    sb_pop(64'(wb_ready_o));
    tick();
    wb_valid_i = '0;
    set_rd(0, 32);
    set_rd(1, 40);
    set_rd(2, 41);
    sb_push("lost_p32", 64'h0);
    sb_push("post_rst_p40", 64'h400);
    sb_push("post_rst_p41", 64'h401);
    #1;
    sb_pop(rdata(0));
    sb_pop(rdata(1));
    sb_pop(rdata(2));

    check_eq("sb_left", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
